// File: rtl/vector_ctrl_pkg.sv
// Shared definitions for the vector run sequencer.
// Holds the default widths, the sequencer state encodings and the
// repeat-count helper (a programmed count of 0 still means one run).
package vector_ctrl_pkg;

   localparam int unsigned A_WIDTH_DEF   = 12;
   localparam int unsigned CNT_WIDTH_DEF = 16;
   localparam int unsigned TO_WIDTH_DEF  = 24;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_LAUNCH    = 3'd1;
   localparam state_t ST_WAIT_DONE = 3'd2;
   localparam state_t ST_GAP       = 3'd3;
   localparam state_t ST_FINISH    = 3'd4;

   function automatic int unsigned eff_repeat(input int unsigned r);
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/vector_run_ctrl_if.sv
// Player / ADC-capture side of the run sequencer.
//   play_go, play_abort         : one-cycle launch / abort pulses to the player
//   play_start_addr/end_addr    : window held stable for the whole sequence
//   play_done                   : one-cycle pulse from the player, window finished
//   adc_start, adc_sequence_one : ADC capture trigger and run-0 marker
// master = sequencer side, slave = player / capture side.
interface vector_run_ctrl_if
   import vector_ctrl_pkg::*;
#(
   parameter int unsigned A_WIDTH = A_WIDTH_DEF
);
   logic               play_go;
   logic               play_abort;
   logic [A_WIDTH-1:0] play_start_addr;
   logic [A_WIDTH-1:0] play_end_addr;
   logic               play_done;
   logic               adc_start;
   logic               adc_sequence_one;

   modport master (
      output play_go, play_abort, play_start_addr, play_end_addr,
             adc_start, adc_sequence_one,
      input  play_done
   );

   modport slave (
      input  play_go, play_abort, play_start_addr, play_end_addr,
             adc_start, adc_sequence_one,
      output play_done
   );
endinterface

// File: rtl/run_watchdog.sv
// Loadable down-counter watchdog.
//   clk, reset_n : clock, synchronous active-low reset
//   load         : load load_val (takes priority over counting)
//   load_val     : reload value; 0 disarms the watchdog
//   en           : count down while high
//   expire       : high during the last permitted enabled cycle
module run_watchdog #(
   parameter int unsigned W = 24
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         expire
);
   logic [W-1:0] cnt;
   logic         armed;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt   <= '0;
         armed <= 1'b0;
      end else if (load) begin
         cnt   <= load_val;
         armed <= |load_val;
      end else if (en && cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   // cnt <= 1 : the budget is used up at the end of this cycle
   assign expire = en && armed && (cnt[W-1:1] == '0);
endmodule

// File: rtl/vector_run_ctrl.sv
// Run sequencer for the JTAG vector player.
//   clk, reset_n       : clock, synchronous active-low reset
//   cmd_start/abort    : one-cycle CPU strobes
//   cfg_*              : window, repeat count, gap, timeout, ADC policy
//   play (master)      : player launch/abort/window and ADC trigger
//   busy/done/err_*    : status; done and err_* are sticky until next start
//   run_count          : completed runs of the current/last sequence
module vector_run_ctrl
   import vector_ctrl_pkg::*;
#(
   parameter int unsigned A_WIDTH   = A_WIDTH_DEF,
   parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF,
   parameter int unsigned TO_WIDTH  = TO_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 cmd_start,
   input  logic                 cmd_abort,
   input  logic [A_WIDTH-1:0]   cfg_vec_start,
   input  logic [A_WIDTH-1:0]   cfg_vec_end,
   input  logic [CNT_WIDTH-1:0] cfg_repeat,
   input  logic [CNT_WIDTH-1:0] cfg_gap,
   input  logic [TO_WIDTH-1:0]  cfg_timeout,
   input  logic                 cfg_adc_every,
   vector_run_ctrl_if.master    play,
   output logic                 busy,
   output logic                 done,
   output logic                 err_cfg,
   output logic                 err_timeout,
   output logic [CNT_WIDTH-1:0] run_count
);
   state_t               state, state_nx;
   logic [A_WIDTH-1:0]   start_sh, end_sh;
   logic [CNT_WIDTH-1:0] rep_sh, gap_sh, gap_cnt, rc_inc;
   logic [TO_WIDTH-1:0]  to_sh, wd_val;
   logic                 every_sh, abort_r;
   logic                 start_req, cfg_ok, abort_req, last_run;
   logic                 wd_load, wd_en, wd_expire;

   assign start_req = cmd_start && !cmd_abort;
   assign cfg_ok    = cfg_vec_start <= cfg_vec_end;
   assign abort_req = cmd_abort && (state != ST_IDLE);
   assign rc_inc    = run_count + CNT_WIDTH'(1);
   assign last_run  = rc_inc == rep_sh;

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:      if (start_req && cfg_ok) state_nx = ST_LAUNCH;
         ST_LAUNCH:    state_nx = ST_WAIT_DONE;
         ST_WAIT_DONE: begin
            if (play.play_done)
               state_nx = last_run ? ST_FINISH :
                          (gap_sh == '0) ? ST_LAUNCH : ST_GAP;
            else if (wd_expire)
               state_nx = ST_IDLE;
         end
         ST_GAP:       if (gap_cnt[CNT_WIDTH-1:1] == '0) state_nx = ST_LAUNCH;
         ST_FINISH:    state_nx = ST_IDLE;
         default:      state_nx = ST_IDLE;
      endcase
      if (abort_req) state_nx = ST_IDLE;
   end

   // The watchdog is loaded on entry to LAUNCH so the launch cycle itself
   // counts against the budget; from IDLE the shadow is not yet valid.
   assign wd_load = state_nx == ST_LAUNCH;
   assign wd_val  = (state == ST_IDLE) ? cfg_timeout : to_sh;
   assign wd_en   = (state == ST_LAUNCH) || (state == ST_WAIT_DONE);

   run_watchdog #(.W(TO_WIDTH)) u_watchdog (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (wd_load),
      .load_val (wd_val),
      .en       (wd_en),
      .expire   (wd_expire)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         start_sh    <= '0;
         end_sh      <= '0;
         rep_sh      <= '0;
         gap_sh      <= '0;
         to_sh       <= '0;
         every_sh    <= 1'b0;
         gap_cnt     <= '0;
         run_count   <= '0;
         abort_r     <= 1'b0;
         done        <= 1'b0;
         err_cfg     <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         state   <= state_nx;
         abort_r <= abort_req;
         case (state)
            ST_IDLE: begin
               if (start_req && cfg_ok) begin
                  start_sh    <= cfg_vec_start;
                  end_sh      <= cfg_vec_end;
                  rep_sh      <= CNT_WIDTH'(eff_repeat(32'(cfg_repeat)));
                  gap_sh      <= cfg_gap;
                  to_sh       <= cfg_timeout;
                  every_sh    <= cfg_adc_every;
                  run_count   <= '0;
                  done        <= 1'b0;
                  err_cfg     <= 1'b0;
                  err_timeout <= 1'b0;
               end else if (start_req) begin
                  err_cfg <= 1'b1;
               end
            end
            ST_WAIT_DONE: begin
               if (!cmd_abort) begin
                  if (play.play_done) begin
                     if (run_count != '1) run_count <= rc_inc;
                     gap_cnt <= gap_sh;
                  end else if (wd_expire) begin
                     err_timeout <= 1'b1;
                     abort_r     <= 1'b1;
                  end
               end
            end
            ST_GAP:    gap_cnt <= gap_cnt - CNT_WIDTH'(1);
            ST_FINISH: if (!cmd_abort) done <= 1'b1;
            default: ;
         endcase
      end
   end

   assign busy                  = (state == ST_LAUNCH) || (state == ST_WAIT_DONE) ||
                                  (state == ST_GAP);
   assign play.play_go          = state == ST_LAUNCH;
   assign play.play_abort       = abort_r;
   assign play.play_start_addr  = start_sh;
   assign play.play_end_addr    = end_sh;
   assign play.adc_start        = (state == ST_LAUNCH) && (every_sh || run_count == '0);
   assign play.adc_sequence_one = ((state == ST_LAUNCH) || (state == ST_WAIT_DONE)) &&
                                  (run_count == '0);
endmodule
